multicycle_ctrl: RTL and testbench

Parametrised multi-cycle control FSM for the accumulator CPU. It sequences fetch, decode, operand fetch, execute and write-back over a shared single-port memory, and drives all datapath enables. Compared with the previous controller it adds:
- a configurable accumulator-file depth,
- a memory ready handshake (wait states),
- a HLT instruction and a clean start/done handshake,
- optional call/return.

---
 rtl/mc_pkg.sv | 54 +++++
 rtl/multicycle_ctrl_if.sv | 45 ++++
 rtl/mc_decode.sv | 43 ++++
 rtl/multicycle_ctrl.sv | 158 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle accumulator-CPU controller.
package mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_FETCH, S_DECODE, S_FETCH2,
    S_MEMRD, S_REGRD, S_EXEC, S_WB, S_JUMP
  } state_t;

  typedef enum logic [1:0] {
    OP_MEM  = 2'd0,
    OP_REG  = 2'd1,
    OP_JMP  = 2'd2,
    OP_MISC = 2'd3
  } op_class_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b01;
  localparam logic [1:0] ALU_SUB = 2'b10;

  localparam logic [1:0] COND_ALW = 2'd0;
  localparam logic [1:0] COND_C   = 2'd1;
  localparam logic [1:0] COND_Z   = 2'd2;
  localparam logic [1:0] COND_N   = 2'd3;

  localparam logic [1:0] MEM_LDA = 2'd0;
  localparam logic [1:0] MEM_STA = 2'd1;
  localparam logic [1:0] MEM_ADD = 2'd2;
  localparam logic [1:0] MEM_AND = 2'd3;

  localparam logic [1:0] REG_MOV = 2'd0;
  localparam logic [1:0] REG_ADD = 2'd1;
  localparam logic [1:0] REG_SUB = 2'd2;
  localparam logic [1:0] REG_AND = 2'd3;

  typedef struct packed {
    op_class_t  cls;
    logic [1:0] op;
    logic [1:0] cond;
    logic       is_call;
    logic       is_hlt;
    logic       is_ret;
  } dec_t;

  // czn is packed {C,Z,N}
  function automatic logic cond_met(input logic [1:0] cond, input logic [2:0] czn);
    case (cond)
      COND_C:  return czn[2];
      COND_Z:  return czn[1];
      COND_N:  return czn[0];
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/handshake bundle between the multi-cycle controller (master) and the datapath/memory (slave).
interface multicycle_ctrl_if #(
  parameter int unsigned ACC_COUNT = 4
) ();
  localparam int unsigned ACC_SEL_W = $clog2(ACC_COUNT);

  logic                 start;
  logic [7:0]           ir;
  logic [2:0]           czn;
  logic                 mem_ready;
  logic                 done;
  logic                 mem_req;
  logic                 mem_we;
  logic                 addr_sel;
  logic                 pc_inc;
  logic                 pc_ld;
  logic                 pc_src;
  logic                 link_we;
  logic                 ir_we;
  logic                 tr_we;
  logic                 a_we;
  logic                 b_we;
  logic                 b_src;
  logic [ACC_SEL_W-1:0] acc_sel;
  logic                 acc_we;
  logic                 a_zero;
  logic                 b_zero;
  logic [1:0]           alu_op;
  logic                 alu_res_we;
  logic                 czn_we;

  modport master (
    input  start, ir, czn, mem_ready,
    output done, mem_req, mem_we, addr_sel, pc_inc, pc_ld, pc_src, link_we,
           ir_we, tr_we, a_we, b_we, b_src, acc_sel, acc_we, a_zero, b_zero,
           alu_op, alu_res_we, czn_we
  );

  modport slave (
    output start, ir, czn, mem_ready,
    input  done, mem_req, mem_we, addr_sel, pc_inc, pc_ld, pc_src, link_we,
           ir_we, tr_we, a_we, b_we, b_src, acc_sel, acc_we, a_zero, b_zero,
           alu_op, alu_res_we, czn_we
  );
endinterface

// File: rtl/mc_decode.sv
// Combinational opcode decoder: ir -> class, op, condition, call/HLT/RET flags and source accumulator.
// MC_CTRL_CALL_EN enables call (jump with ir[2]=1) and RET; otherwise both flags stay 0.
module mc_decode
  import mc_pkg::*;
#(
  parameter int unsigned ACC_COUNT = 4,
  localparam int unsigned ACC_SEL_W = $clog2(ACC_COUNT)
) (
  input  logic [7:0]           i_ir,
  output dec_t                 o_dec,
  output logic [ACC_SEL_W-1:0] o_src
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    o_dec = '0;
    case (i_ir[7:5])
      3'b100, 3'b101: o_dec.cls = OP_REG;
      3'b110:         o_dec.cls = OP_JMP;
      3'b111:         o_dec.cls = OP_MISC;
      default:        o_dec.cls = OP_MEM;
    endcase
    o_dec.op     = (o_dec.cls == OP_MEM) ? i_ir[6:5] : i_ir[4:3];
    o_dec.cond   = i_ir[4:3];
    o_dec.is_hlt = (o_dec.cls == OP_MISC) && (i_ir[1:0] == 2'b01);
`ifdef MC_CTRL_CALL_EN
    o_dec.is_call = (o_dec.cls == OP_JMP) && i_ir[2];
    o_dec.is_ret  = (o_dec.cls == OP_MISC) && (i_ir[1:0] == 2'b10);
`else
    o_dec.is_call = 1'b0;
    o_dec.is_ret  = 1'b0;
`endif
  end

`ifndef MC_CTRL_CALL_EN
  logic w_unused_call_bit;
  assign w_unused_call_bit = i_ir[2];
`endif

  // Non-power-of-two files wrap the register field back into range.
  assign o_src = ACC_SEL_W'(32'(i_ir[ACC_SEL_W-1:0]) % ACC_COUNT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: fetch/decode/operand/execute/write-back over a shared memory with wait states.
// Call/RET support is compiled in with MC_CTRL_CALL_EN (handled in mc_decode).
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int unsigned ACC_COUNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  multicycle_ctrl_if.master bus
);

  localparam int unsigned ACC_SEL_W = $clog2(ACC_COUNT);

  state_t               r_state;
  state_t               w_state_nxt;
  dec_t                 w_dec;
  logic [ACC_SEL_W-1:0] w_src;
  logic                 w_take;
  logic                 w_sta;

  mc_decode #(.ACC_COUNT(ACC_COUNT)) u_decode (
    .i_ir  (bus.ir),
    .o_dec (w_dec),
    .o_src (w_src)
  );

  assign w_take = cond_met(w_dec.cond, bus.czn);
  assign w_sta  = (w_dec.cls == OP_MEM) && (w_dec.op == MEM_STA);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    bus.done       = 1'b0;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.addr_sel   = 1'b0;
    bus.pc_inc     = 1'b0;
    bus.pc_ld      = 1'b0;
    bus.pc_src     = 1'b0;
    bus.link_we    = 1'b0;
    bus.ir_we      = 1'b0;
    bus.tr_we      = 1'b0;
    bus.a_we       = 1'b0;
    bus.b_we       = 1'b0;
    bus.b_src      = 1'b0;
    bus.acc_sel    = '0;
    bus.acc_we     = 1'b0;
    bus.a_zero     = 1'b0;
    bus.b_zero     = 1'b0;
    bus.alu_op     = ALU_ADD;
    bus.alu_res_we = 1'b0;
    bus.czn_we     = 1'b0;

    case (r_state)
      S_IDLE: begin
        bus.done = 1'b1;
        if (bus.start) w_state_nxt = S_START;
      end
      S_START: if (!bus.start) w_state_nxt = S_FETCH;
      S_FETCH: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ready) begin
          bus.ir_we   = 1'b1;
          bus.pc_inc  = 1'b1;
          w_state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        case (w_dec.cls)
          OP_MEM, OP_JMP: w_state_nxt = S_FETCH2;
          OP_REG:         w_state_nxt = S_REGRD;
          default: begin
            if (w_dec.is_hlt)      w_state_nxt = S_IDLE;
            else if (w_dec.is_ret) w_state_nxt = S_JUMP;
            else                   w_state_nxt = S_FETCH;
          end
        endcase
      end
      S_FETCH2: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ready) begin
          bus.tr_we   = 1'b1;
          bus.pc_inc  = 1'b1;
          w_state_nxt = (w_dec.cls == OP_JMP) ? S_JUMP : S_MEMRD;
        end
      end
      S_MEMRD: begin
        if (w_sta) begin
          bus.a_we    = 1'b1;
          w_state_nxt = S_EXEC;
        end else begin
          bus.mem_req  = 1'b1;
          bus.addr_sel = 1'b1;
          if (bus.mem_ready) begin
            bus.b_we    = 1'b1;
            bus.b_src   = 1'b1;
            bus.a_we    = 1'b1;
            w_state_nxt = S_EXEC;
          end
        end
      end
      S_REGRD: begin
        bus.b_we    = 1'b1;
        bus.acc_sel = w_src;
        bus.a_we    = 1'b1;
        w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        bus.alu_res_we = 1'b1;
        w_state_nxt    = S_WB;
        if (w_dec.cls == OP_MEM) begin
          case (w_dec.op)
            MEM_LDA: bus.a_zero = 1'b1;
            MEM_STA: bus.b_zero = 1'b1;
            MEM_ADD: bus.czn_we = 1'b1;
            default: begin bus.alu_op = ALU_AND; bus.czn_we = 1'b1; end
          endcase
        end else begin
          case (w_dec.op)
            REG_MOV: bus.a_zero = 1'b1;
            REG_ADD: bus.czn_we = 1'b1;
            REG_SUB: begin bus.alu_op = ALU_SUB; bus.czn_we = 1'b1; end
            default: begin bus.alu_op = ALU_AND; bus.czn_we = 1'b1; end
          endcase
        end
      end
      S_WB: begin
        if (w_sta) begin
          bus.mem_req  = 1'b1;
          bus.mem_we   = 1'b1;
          bus.addr_sel = 1'b1;
          if (bus.mem_ready) w_state_nxt = S_FETCH;
        end else begin
          bus.acc_we  = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      S_JUMP: begin
        w_state_nxt = S_FETCH;
        if (w_dec.is_ret) begin
          bus.pc_ld  = 1'b1;
          bus.pc_src = 1'b1;
        end else begin
          bus.pc_ld   = w_take;
          bus.link_we = w_take & w_dec.is_call;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction pulse counts and qualifiers against a spec-level model.
module tb_multicycle_ctrl;

  localparam int ACC_N = 3;
  localparam int SEL_W = $clog2(ACC_N);
`ifdef MC_CTRL_CALL_EN
  localparam bit CALL_EN = 1'b1;
`else
  localparam bit CALL_EN = 1'b0;
`endif

  typedef struct packed {
    int irw, trw, bw, aw, alu, cznw, accw, pci, pcl, lnk, memw, rdreq;
  } cnt_t;

  typedef struct packed {
    logic [2:0] bsel;
    logic       bsrc;
    logic [1:0] aop;
    logic       az;
    logic       bz;
    logic       psrc;
    logic [2:0] wsel;
  } qual_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  multicycle_ctrl_if #(.ACC_COUNT(ACC_N)) bus ();
  multicycle_ctrl #(.ACC_COUNT(ACC_N)) dut (.clk(clk), .rst(rst_n), .bus(bus));

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [18:0] outs();
    return {bus.mem_req, bus.mem_we, bus.addr_sel, bus.pc_inc, bus.pc_ld, bus.pc_src,
            bus.link_we, bus.ir_we, bus.tr_we, bus.a_we, bus.b_we, bus.b_src,
            |bus.acc_sel, bus.acc_we, bus.a_zero, bus.b_zero, |bus.alu_op,
            bus.alu_res_we, bus.czn_we};
  endfunction

  // Reference: what one instruction must do, derived from the instruction set rules.
  function automatic void model(input logic [7:0] b, input logic [2:0] cz,
                                input int wf, input int wf2, input int wm, input int wwb,
                                output cnt_t e, output qual_t q, output int cyc);
    logic ok;
    e = '0;
    q = '0;
    e.irw = 1;
    e.pci = 1;
    if (!b[7]) begin
      e.trw = 1; e.pci = 2; e.aw = 1; e.alu = 1;
      cyc = 6 + wf + wf2;
      if (b[6:5] == 2'd1) begin
        cyc    += wwb;
        e.memw  = 1 + wwb;
        e.rdreq = 1 + wwb;
        q.bz    = 1'b1;
      end else begin
        cyc    += wm;
        e.bw    = 1;
        e.accw  = 1;
        e.rdreq = 1 + wm;
        q.bsrc  = 1'b1;
        q.az    = (b[6:5] == 2'd0);
        e.cznw  = (b[6:5] != 2'd0) ? 1 : 0;
        q.aop   = (b[6:5] == 2'd3) ? 2'b01 : 2'b00;
      end
    end else if (!b[6]) begin
      cyc = 5 + wf;
      e.aw = 1; e.bw = 1; e.alu = 1; e.accw = 1;
      q.bsel = 3'((int'(b) % (1 << SEL_W)) % ACC_N);
      e.cznw = (b[4:3] != 2'd0) ? 1 : 0;
      q.az   = (b[4:3] == 2'd0);
      case (b[4:3])
        2'd2:    q.aop = 2'b10;
        2'd3:    q.aop = 2'b01;
        default: q.aop = 2'b00;
      endcase
    end else if (!b[5]) begin
      cyc = 4 + wf + wf2;
      e.trw = 1; e.pci = 2;
      case (b[4:3])
        2'd0:    ok = 1'b1;
        2'd1:    ok = cz[2];
        2'd2:    ok = cz[1];
        default: ok = cz[0];
      endcase
      e.pcl = ok ? 1 : 0;
      e.lnk = (ok && CALL_EN && b[2]) ? 1 : 0;
    end else begin
      if (CALL_EN && b[1:0] == 2'd2) begin
        cyc = 3 + wf;
        e.pcl  = 1;
        q.psrc = 1'b1;
      end else begin
        cyc = 2 + wf;
      end
    end
  endfunction

  // Runs one instruction starting at its first FETCH cycle, answering memory with the given wait counts.
  task automatic exec_instr(input string nm, input logic [7:0] b1, input logic [2:0] cz,
                            input int wf, input int wf2, input int wm, input int wwb);
    cnt_t  o, e;
    qual_t qo, qe;
    int    cyc, bad;
    int    wq[$];
    logic  prev_wait, prev_as, pend;
    model(b1, cz, wf, wf2, wm, wwb, e, qe, cyc);
    wq = {wf, wf2, (!b1[7] && b1[6:5] == 2'd1) ? wwb : wm};
    o = '0; qo = '0; bad = 0; prev_wait = 1'b0; prev_as = 1'b0; pend = 1'b0;
    bus.czn = cz;
    for (int c = 0; c < cyc; c++) begin
      @(negedge clk);
      if (pend) begin bus.ir = b1; pend = 1'b0; end
      #1;
      if (bus.mem_req) begin
        if (prev_wait && bus.addr_sel !== prev_as) bad++;
        if (wq.size() > 0 && wq[0] > 0) begin
          bus.mem_ready = 1'b0;
          wq[0]--;
        end else begin
          bus.mem_ready = 1'b1;
          if (wq.size() > 0) void'(wq.pop_front());
        end
      end else begin
        if (prev_wait) bad++;
        bus.mem_ready = 1'($urandom);
      end
      #1;
      prev_wait = bus.mem_req && !bus.mem_ready;
      prev_as   = bus.addr_sel;
      if (c == 0 && !(bus.mem_req === 1'b1 && bus.addr_sel === 1'b0)) bad++;
      if (bus.done !== 1'b0) bad++;
      if ((bus.a_zero || bus.b_zero) && !bus.alu_res_we) bad++;
      if (bus.mem_we && !bus.mem_req) bad++;
      if ((bus.link_we || bus.pc_src) && !bus.pc_ld) bad++;
      if (bus.ir_we) begin o.irw++; pend = 1'b1; end
      if (bus.tr_we)      o.trw++;
      if (bus.a_we)       o.aw++;
      if (bus.alu_res_we) o.alu++;
      if (bus.czn_we)     o.cznw++;
      if (bus.acc_we)     o.accw++;
      if (bus.pc_inc)     o.pci++;
      if (bus.pc_ld)      o.pcl++;
      if (bus.link_we)    o.lnk++;
      if (bus.mem_we)     o.memw++;
      if (bus.mem_req && bus.addr_sel) o.rdreq++;
      if (bus.b_we) begin
        o.bw++;
        qo.bsel = 3'(bus.acc_sel);
        qo.bsrc = bus.b_src;
      end
      if (bus.alu_res_we) begin
        qo.aop = bus.alu_op;
        qo.az  = bus.a_zero;
        qo.bz  = bus.b_zero;
      end
      if (bus.pc_ld)  qo.psrc = bus.pc_src;
      if (bus.acc_we) qo.wsel = 3'(bus.acc_sel);
    end
    n_tests++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL %s_counts ir=%h got %p want %p", nm, b1, o, e);
    end
    n_tests++;
    if (qo !== qe) begin
      n_fail++;
      $display("FAIL %s_qual ir=%h got %p want %p", nm, b1, qo, qe);
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s_protocol ir=%h got %0d violations want 0", nm, b1, bad);
    end
  endtask

  task automatic start_program();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    n_tests++;
    if (bus.done !== 1'b0 || bus.mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL start_state got done=%b mem_req=%b want 0 0", bus.done, bus.mem_req);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b1; bus.mem_ready = 1'b1; bus.ir = 8'h00; bus.czn = 3'b000;
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (outs() !== '0 || bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_outputs got outs=%h done=%b want 0 1", outs(), bus.done);
    end
    bus.start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    n_tests++;
    if (bus.done !== 1'b1 || bus.mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold got done=%b mem_req=%b want 1 0", bus.done, bus.mem_req);
    end
  endtask

  task automatic test_reg_ops();
    exec_instr("reg_mov", 8'h85, 3'b000, 0, 0, 0, 0);
    exec_instr("reg_add", 8'h8D, 3'b000, 0, 0, 0, 0);
    exec_instr("reg_sub", 8'h92, 3'b000, 1, 0, 0, 0);
    exec_instr("reg_and_wrap", 8'h9B, 3'b000, 0, 0, 0, 0);
  endtask

  task automatic test_lda_waits();
    exec_instr("lda_wait", 8'h00, 3'b000, 2, 2, 0, 0);
    exec_instr("mem_add_wait", 8'h40, 3'b000, 0, 1, 3, 0);
  endtask

  task automatic test_jump();
    exec_instr("jz_taken", 8'hD0, 3'b010, 0, 0, 0, 0);
    exec_instr("jz_not", 8'hD0, 3'b000, 0, 0, 0, 0);
    exec_instr("jc_wait", 8'hC8, 3'b100, 1, 2, 0, 0);
  endtask

  task automatic test_sta();
    exec_instr("sta_wb_wait", 8'h20, 3'b000, 0, 0, 0, 3);
    exec_instr("sta_nowait", 8'h20, 3'b111, 0, 0, 0, 0);
  endtask

  task automatic test_call_ret();
    exec_instr("call_taken", 8'hD4, 3'b010, 0, 0, 0, 0);
    exec_instr("call_not", 8'hD4, 3'b000, 0, 0, 0, 0);
    exec_instr("ret", 8'hE2, 3'b000, 1, 0, 0, 0);
    exec_instr("nop", 8'hE0, 3'b000, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int i = 0; i < 40; i++) begin
      do b = 8'($urandom); while (b[7:5] == 3'b111 && b[1:0] == 2'b01);
      exec_instr("rand", b, 3'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
                 $urandom_range(0, 2), $urandom_range(0, 2));
    end
  endtask

  task automatic test_hlt();
    int bad;
    bus.start = 1'b1;
    exec_instr("hlt_start_high", 8'hE1, 3'b000, 1, 0, 0, 0);
    @(negedge clk);
    #2;
    n_tests++;
    if (bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL hlt_done got %b want 1", bus.done);
    end
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      #2;
      if (bus.done !== 1'b0 || bus.mem_req !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL start_hold got %0d bad cycles want 0", bad);
    end
    bus.start = 1'b0;
    exec_instr("after_start_drop", 8'hE0, 3'b000, 0, 0, 0, 0);
    exec_instr("hlt", 8'hE1, 3'b000, 0, 0, 0, 0);
    @(negedge clk);
    #2;
    n_tests++;
    if (bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL hlt_done2 got %b want 1", bus.done);
    end
    start_program();
    exec_instr("restart", 8'h8D, 3'b000, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.mem_ready = 1'b1;
    @(negedge clk);
    bus.ir = 8'hD0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
    n_tests++;
    if (bus.mem_req !== 1'b1 || bus.addr_sel !== 1'b0 || bus.tr_we !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch2_wait got req=%b sel=%b tr_we=%b want 1 0 0", bus.mem_req, bus.addr_sel, bus.tr_we);
    end
    #1;
    rst_n = 1'b0;
    bus.start = 1'b1;
    #1;
    n_tests++;
    if (outs() !== '0 || bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid got outs=%h done=%b want 0 1", outs(), bus.done);
    end
    bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (outs() !== '0 || bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_hold got outs=%h done=%b want 0 1", outs(), bus.done);
    end
    bus.start = 1'b0;
    rst_n = 1'b1;
    start_program();
    exec_instr("post_reset_nop", 8'hE0, 3'b000, 0, 0, 0, 0);
    exec_instr("post_reset_hlt", 8'hE1, 3'b000, 0, 0, 0, 0);
    @(negedge clk);
    #2;
    n_tests++;
    if (bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL final_done got %b want 1", bus.done);
    end
  endtask

  initial begin
    test_reset();
    start_program();
    test_reg_ops();
    test_lda_waits();
    test_jump();
    test_sta();
    test_call_ret();
    test_random();
    test_hlt();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
